// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding and default widths for the sweep controller
package sweep_pkg;
    localparam int W_DEF  = 8;
    localparam int DW_DEF = 4;
    typedef enum logic [2:0] {IDLE, SEEK, UP, DWELL_HI, DOWN, DWELL_LO} state_t;
endpackage

// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: sweep command inputs and count/status outputs
interface sweep_ctrl_if import sweep_pkg::*; #(parameter int W = W_DEF, parameter int DW = DW_DEF);
    logic          start, stop, mode;
    logic [W-1:0]  lo, hi;
    logic [DW-1:0] dwell;
    logic [W-1:0]  count;
    logic          ss, ud, busy, done, err;
    modport master (output start, stop, mode, lo, hi, dwell, input count, ss, ud, busy, done, err);
    modport slave  (input start, stop, mode, lo, hi, dwell, output count, ss, ud, busy, done, err);
endinterface

// File: rtl/step_cnt8.sv
// step_cnt8: W-bit up/down step register with enable and synchronous clear
module step_cnt8 import sweep_pkg::*; #(parameter int W = W_DEF) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= clr ? '0 : en ? (up ? q + 1'b1 : q - 1'b1) : q;
endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: bounded lo/hi counter sweep with endpoint dwell, single or triangle mode
module sweep_ctrl import sweep_pkg::*; #(parameter int W = W_DEF, parameter int DW = DW_DEF) (
    input logic        clk,
    input logic        reset,
    sweep_ctrl_if.slave bus
);
    state_t        state;
    logic [W-1:0]  lo_q, hi_q, nxt;
    logic [DW-1:0] dwell_q, tmr;
    logic          mode_q, step, dir;
    always_comb begin
        step = !bus.stop && (state == SEEK || state == UP || state == DOWN);
        dir  = state == SEEK ? bus.count < lo_q : state == UP;
        nxt  = dir ? bus.count + 1'b1 : bus.count - 1'b1;
    end
    step_cnt8 #(.W(W)) u_cnt (.clk, .clr(reset), .en(step), .up(dir), .q(bus.count));
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            dwell_q  <= '0;
            mode_q   <= 1'b0;
            tmr      <= '0;
            bus.ss   <= 1'b0;
            bus.ud   <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.ss   <= step;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            if (step) bus.ud <= dir;
            if (state != IDLE && bus.stop) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                tmr      <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.start && !bus.stop) begin
                        if (bus.lo < bus.hi) begin
                            lo_q     <= bus.lo;
                            hi_q     <= bus.hi;
                            mode_q   <= bus.mode;
                            dwell_q  <= bus.dwell;
                            state    <= bus.count == bus.lo ? UP : SEEK;
                            bus.busy <= 1'b1;
                        end else bus.err <= 1'b1;
                    end
                    SEEK: if (nxt == lo_q) state <= UP;
                    UP: if (nxt == hi_q) begin
                        if (dwell_q != '0) begin
                            state <= DWELL_HI;
                            tmr   <= dwell_q;
                        end else if (mode_q) state <= DOWN;
                        else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end
                    DWELL_HI: if (tmr > DW'(1)) tmr <= tmr - 1'b1;
                    else begin
                        tmr <= '0;
                        if (mode_q) state <= DOWN;
                        else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end
                    DOWN: if (nxt == lo_q) begin
                        if (dwell_q != '0) begin
                            state <= DWELL_LO;
                            tmr   <= dwell_q;
                        end else state <= UP;
                    end
                    DWELL_LO: if (tmr > DW'(1)) tmr <= tmr - 1'b1;
                    else begin
                        tmr   <= '0;
                        state <= UP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed and random sweeps checked against a trajectory model
module tb_sweep_ctrl;
    typedef struct {int count; bit ss; bit ud; bit busy; bit done;} rec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   m_count = 0;
    bit   m_ud = 1'b1;
    int   age = 0;
    rec_t q[$];
    sweep_ctrl_if #(.W(8), .DW(4)) bus();
    sweep_ctrl #(.W(8), .DW(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic push(input int c, input bit ss, input bit ud, input bit busy);
        q.push_back('{c, ss, ud, busy, 1'b0});
    endtask
    // Expected post-edge values for every edge from the accepting one until the sweep ends
    task automatic plan(input int c0, input int lo, input int hi, input int d, input bit mode, input bit u0);
        int c = c0;
        bit u = u0;
        rec_t r;
        push(c, 1'b0, u, 1'b1);
        while (c != lo) begin
            u = c < lo;
            c = u ? c + 1 : c - 1;
            push(c, 1'b1, u, 1'b1);
        end
        while (q.size() < 600) begin
            while (c != hi) begin c++; u = 1'b1; push(c, 1'b1, u, 1'b1); end
            repeat (d) push(c, 1'b0, u, 1'b1);
            if (!mode) begin
                r = q[q.size()-1];
                r.busy = 1'b0;
                r.done = 1'b1;
                q[q.size()-1] = r;
                return;
            end
            while (c != lo) begin c--; u = 1'b0; push(c, 1'b1, u, 1'b1); end
            repeat (d) push(c, 1'b0, u, 1'b1);
        end
    endtask
    task automatic tick();
        rec_t e;
        bit   eerr = 1'b0;
        @(posedge clk);
        e = '{m_count, 1'b0, m_ud, 1'b0, 1'b0};
        if (reset) begin
            q.delete();
            e = '{0, 1'b0, 1'b1, 1'b0, 1'b0};
        end else if (q.size() > 0) begin
            if (bus.stop) q.delete();
            else e = q.pop_front();
        end else if (bus.start && !bus.stop) begin
            if (bus.lo < bus.hi) begin
                plan(m_count, int'(bus.lo), int'(bus.hi), int'(bus.dwell), bus.mode, m_ud);
                e = q.pop_front();
            end else eerr = 1'b1;
        end
        m_count = e.count;
        m_ud = e.ud;
        #1;
        chk("count", 32'(bus.count), 32'(e.count));
        chk("ss", 32'(bus.ss), 32'(e.ss));
        chk("ud", 32'(bus.ud), 32'(e.ud));
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("done", 32'(bus.done), 32'(e.done));
        chk("err", 32'(bus.err), 32'(eerr));
    endtask
    task automatic go(input bit mode, input int lo, input int hi, input int d);
        bus.mode = mode;
        bus.lo = 8'(lo);
        bus.hi = 8'(hi);
        bus.dwell = 4'(d);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.mode = 1'b0;
        bus.lo = '0;
        bus.hi = '0;
        bus.dwell = '0;
        do_reset();
        go(1'b0, 3, 6, 2);
        repeat (12) tick();
        do_reset();
        go(1'b1, 2, 4, 0);
        repeat (14) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        go(1'b0, 5, 5, 1);
        repeat (3) tick();
        do_reset();
        go(1'b0, 0, 9, 0);
        for (int i = 0; i < 20 && m_count != 4; i++) tick();
        chk("abort_at4", 32'(bus.count), 32'd4);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        repeat (2) tick();
        do_reset();
        go(1'b0, 0, 9, 0);
        for (int i = 0; i < 30 && q.size() > 0; i++) tick();
        chk("at9", 32'(bus.count), 32'd9);
        go(1'b0, 2, 7, 1);
        repeat (3) tick();
        go(1'b1, 0, 12, 3);
        repeat (20) tick();
        bus.stop = 1'b1;
        go(1'b0, 0, 9, 0);
        bus.stop = 1'b0;
        repeat (3) tick();
        do_reset();
        go(1'b1, 0, 8, 0);
        for (int i = 0; i < 40 && !(q.size() > 0 && !m_ud && m_count == 5); i++) tick();
        chk("down_at5", 32'(bus.count), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4000; i++) begin
            age = q.size() > 0 ? age + 1 : 0;
            reset = $urandom_range(0, 299) == 0;
            bus.stop = ($urandom_range(0, 39) == 0) || age > 300;
            bus.start = $urandom_range(0, 3) == 0;
            bus.mode = 1'($urandom);
            bus.lo = 8'($urandom_range(0, 20));
            bus.hi = 8'($urandom_range(0, 20));
            bus.dwell = $urandom_range(0, 7) == 0 ? 4'd15 : 4'($urandom_range(0, 3));
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
